// File: rtl/lab_step_sequencer.sv
// Button front end and U-vector source for the lab control automaton: sync, debounce, step strobes, playback table.
// Build option LAB_STEP_DEBOUNCE_EN: defined builds the debounce counter, undefined passes the synchronized level straight through.
//
// state | meaning
// IDLE  | manual steps on each press; a press in playback mode starts RUN
// RUN   | replaying table entries, one step every PERIOD cycles
// DONE  | last entry issued; waiting for a press to return to IDLE
module lab_step_sequencer #(
  parameter int DEB_CYCLES = 16,
  parameter int PERIOD     = 64,
  parameter int AW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          count,
  input  logic          mode,
  input  logic [7:0]    U_sw,
  input  logic [AW-1:0] vec_last,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic [7:0]    U,
  output logic          step,
  output logic [AW-1:0] idx,
  output logic [1:0]    seq_state,
  output logic          press
);

  localparam int DEPTH = 1 << AW;
  localparam int PER_W = $clog2(PERIOD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  logic s1_d, s1_q, s2_d, s2_q;
  logic press_lvl;
  logic press_dly_d, press_dly_q;
  logic press_p_d, press_p_q;

  state_e            state_d, state_q;
  logic              step_d, step_q;
  logic [7:0]        u_d, u_q;
  logic [AW-1:0]     idx_d, idx_q;
  logic [AW-1:0]     idx_nxt;
  logic [PER_W-1:0]  per_cnt_d, per_cnt_q;
  logic [7:0]        tbl_d [DEPTH];
  logic [7:0]        tbl_q [DEPTH];

`ifdef LAB_STEP_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES);

  logic [DEB_W-1:0] deb_cnt_d, deb_cnt_q;
  logic             press_d, press_q;

  // A level change is accepted only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    deb_cnt_d = '0;
    press_d   = press_q;
    if (s2_q != press_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        press_d = s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
    end
  end

  assign press_lvl = press_q;
`else
  assign press_lvl = s2_q;
`endif

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    s1_d        = count;
    s2_d        = s1_q;
    press_dly_d = press_lvl;
    press_p_d   = press_lvl & ~press_dly_q;

    state_d   = state_q;
    step_d    = 1'b0;
    u_d       = u_q;
    idx_d     = idx_q;
    per_cnt_d = per_cnt_q;

    tbl_d = tbl_q;
    if (wr_en) begin
      tbl_d[wr_addr] = wr_data;
    end

    case (state_q)
      IDLE: begin
        if (press_p_q) begin
          step_d = 1'b1;
          if (!mode) begin
            u_d = U_sw;
          end else begin
            u_d       = tbl_q[0];
            idx_d     = '0;
            per_cnt_d = '0;
            state_d   = (vec_last == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        // An abort press wins over a step that falls due in the same cycle.
        if (press_p_q) begin
          state_d = IDLE;
        end else if (per_cnt_q == PER_W'(PERIOD - 1)) begin
          step_d    = 1'b1;
          idx_d     = idx_nxt;
          u_d       = tbl_q[idx_nxt];
          per_cnt_d = '0;
          if (idx_nxt == vec_last) begin
            state_d = DONE;
          end
        end else begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (press_p_q) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      press_dly_q <= 1'b0;
      press_p_q   <= 1'b0;
      state_q     <= IDLE;
      step_q      <= 1'b0;
      u_q         <= '0;
      idx_q       <= '0;
      per_cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      press_dly_q <= press_dly_d;
      press_p_q   <= press_p_d;
      state_q     <= state_d;
      step_q      <= step_d;
      u_q         <= u_d;
      idx_q       <= idx_d;
      per_cnt_q   <= per_cnt_d;
      tbl_q       <= tbl_d;
    end
  end

  assign U         = u_q;
  assign step      = step_q;
  assign idx       = idx_q;
  assign seq_state = state_q;
  assign press     = press_lvl;

endmodule
